// File: rtl/ram_dma_pkg.sv
// Shared constants and FSM state encoding for the ram_dma block copy/fill engine.
package ram_dma_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 16;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_dma.sv
// Block copy/fill engine mastering RAM port B; one byte per WR state, done pulse at end.
// Optional macro RAM_DMA_OVERLAP_EN: descending copy for forward-overlapping ranges (memmove).
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_W,
  parameter int ADDR_WIDTH = RAM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] remaining,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] src_q, src_nxt;
  logic [ADDR_WIDTH-1:0] dst_q, dst_nxt;
  logic                  mode_q, mode_nxt;
  logic [DATA_WIDTH-1:0] fill_q, fill_nxt;
  logic                  abort_seen, abort_nxt;
  logic                  busy_nxt, done_nxt, we_nxt;
  logic [ADDR_WIDTH-1:0] rem_nxt, addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic                  dir_down;

  function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic down);
    return down ? (a - ONE) : (a + ONE);
  endfunction

`ifdef RAM_DMA_OVERLAP_EN
  logic                  down_q, down_nxt;
  logic [ADDR_WIDTH-1:0] diff;
  // dst inside (src, src+length-1] means an ascending copy would clobber unread source.
  assign diff     = dst_addr - src_addr;
  assign dir_down = down_q;
`else
  assign dir_down = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    mode_nxt  = mode_q;
    fill_nxt  = fill_q;
    abort_nxt = abort_seen | (busy & abort);
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    rem_nxt   = remaining;
    we_nxt    = 1'b0;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
`ifdef RAM_DMA_OVERLAP_EN
    down_nxt  = down_q;
`endif
    case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (start) begin
          if (length != '0) begin
            src_nxt   = src_addr;
            dst_nxt   = dst_addr;
            mode_nxt  = mode;
            fill_nxt  = fill_data;
            rem_nxt   = length;
            busy_nxt  = 1'b1;
            state_nxt = (mode == MODE_FILL) ? WR : RD;
`ifdef RAM_DMA_OVERLAP_EN
            down_nxt  = 1'b0;
            if (mode == MODE_COPY && diff != '0 && diff < length) begin
              down_nxt = 1'b1;
              src_nxt  = src_addr + length - ONE;
              dst_nxt  = dst_addr + length - ONE;
            end
`endif
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RD: begin
        addr_nxt  = src_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = WR;
      end
      WR: begin
        wdata_nxt = (mode_q == MODE_FILL) ? fill_q : mem_rdata;
        addr_nxt  = dst_q;
        we_nxt    = 1'b1;
        rem_nxt   = remaining - ONE;
        src_nxt   = step(src_q, dir_down);
        dst_nxt   = step(dst_q, dir_down);
        if (remaining == ONE || abort || abort_seen) begin
          state_nxt = FIN;
        end else begin
          state_nxt = (mode_q == MODE_FILL) ? WR : RD;
        end
      end
      FIN: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        abort_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      abort_seen <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      abort_seen <= abort_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      remaining  <= rem_nxt;
      mem_we     <= we_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
    end
  end

  // Latched command parameters; only meaningful while busy, so no reset needed.
  always_ff @(posedge clk) begin
    src_q  <= src_nxt;
    dst_q  <= dst_nxt;
    mode_q <= mode_nxt;
    fill_q <= fill_nxt;
`ifdef RAM_DMA_OVERLAP_EN
    down_q <= down_nxt;
`endif
  end

endmodule

// File: tb/tb_ram_dma.sv
// Directed self-checking bench for ram_dma with a 64KB one-cycle-latency RAM model on port B.
module tb_ram_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic [7:0]  fill_data = '0;
  logic        abort = 1'b0;
  logic        busy, done, mem_we;
  logic [15:0] remaining, mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  rdata = '0;

  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  mem [0:65535];
  int          wr_cnt = 0;
  int          done_cnt = 0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ram_dma dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
    .remaining(remaining), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    rdata <= mem[mem_addr];
    if (mem_we) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic m, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] n, input logic [7:0] f);
    mode = m; src_addr = s; dst_addr = d; length = n; fill_data = f; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 40 && done !== 1'b1; i++) tick();
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int          snap_wr, snap_done;
    logic [15:0] ea;
    logic [7:0]  cp [3];
    logic [7:0]  ov [4];
    cp = '{8'h11, 8'h22, 8'h33};
`ifdef RAM_DMA_OVERLAP_EN
    ov = '{8'h01, 8'h02, 8'h03, 8'h04};
`else
    ov = '{8'h01, 8'h01, 8'h01, 8'h01};
`endif

    // reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    tick();

    // fill 4 bytes of A5 at 0x1000
    issue(1'b1, 16'h0000, 16'h1000, 16'd4, 8'hA5);
    chk("fill_busy", 32'(busy), 32'd1);
    chk("fill_we0", 32'(mem_we), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_we", 32'(mem_we), 32'd1);
      chk("fill_addr", 32'(mem_addr), 32'h1000 + 32'(i));
      chk("fill_data", 32'(mem_wdata), 32'hA5);
    end
    tick();
    chk("fill_done", 32'(done), 32'd1);
    chk("fill_rem", 32'(remaining), 32'd0);
    chk("fill_busy_end", 32'(busy), 32'd0);
    chk("fill_we_end", 32'(mem_we), 32'd0);
    tick();
    chk("fill_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) chk("fill_mem", 32'(mem[16'h1000 + 16'(i)]), 32'hA5);

    // copy 3 bytes 0x0200 -> 0x0300, with an ignored start while busy
    preload(16'h0200, 8'h11);
    preload(16'h0201, 8'h22);
    preload(16'h0202, 8'h33);
    preload(16'h5000, 8'h5A);
    issue(1'b0, 16'h0200, 16'h0300, 16'd3, 8'h00);
    chk("copy_busy1", 32'(busy), 32'd1);
    for (int k = 2; k <= 11; k++) begin
      if (k == 3) begin
        mode = 1'b1; dst_addr = 16'h5000; length = 16'd2; fill_data = 8'hEE; start = 1'b1;
      end
      tick();
      start = 1'b0;
      chk("copy_we", 32'(mem_we), (k == 4 || k == 7 || k == 10) ? 32'd1 : 32'd0);
      chk("copy_busy", 32'(busy), (k <= 10) ? 32'd1 : 32'd0);
      chk("copy_done", 32'(done), (k == 11) ? 32'd1 : 32'd0);
      if (k == 4 || k == 7 || k == 10) begin
        chk("copy_addr", 32'(mem_addr), 32'h0300 + 32'((k - 4) / 3));
        chk("copy_wdata", 32'(mem_wdata), 32'(cp[(k - 4) / 3]));
      end
    end
    chk("copy_rem", 32'(remaining), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) chk("copy_mem", 32'(mem[16'h0300 + 16'(i)]), 32'(cp[i]));
    chk("busy_start_ignored", 32'(mem[16'h5000]), 32'h5A);

    // fill across the top of the address space
    issue(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      tick();
      ea = 16'hFFFE + 16'(i);
      chk("wrap_we", 32'(mem_we), 32'd1);
      chk("wrap_addr", 32'(mem_addr), 32'(ea));
    end
    tick();
    chk("wrap_done", 32'(done), 32'd1);
    tick();

    // abort during the third byte of a 10-byte fill
    preload(16'h2003, 8'h12);
    snap_wr = wr_cnt;
    issue(1'b1, 16'h0000, 16'h2000, 16'd10, 8'h77);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    tick();
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_rem", 32'(remaining), 32'd7);
    chk("abort_busy_end", 32'(busy), 32'd0);
    chk("abort_writes", 32'(wr_cnt - snap_wr), 32'd3);
    tick();
    chk("abort_mem2", 32'(mem[16'h2002]), 32'h77);
    chk("abort_mem3", 32'(mem[16'h2003]), 32'h12);

    // zero-length command
    snap_wr = wr_cnt;
    issue(1'b1, 16'h0000, 16'h4000, 16'd0, 8'h99);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_we", 32'(mem_we), 32'd0);
    tick();
    chk("len0_pulse", 32'(done), 32'd0);
    chk("len0_writes", 32'(wr_cnt - snap_wr), 32'd0);

    // overlapping forward copy 0x10 -> 0x11
    preload(16'h0010, 8'h01);
    preload(16'h0011, 8'h02);
    preload(16'h0012, 8'h03);
    preload(16'h0013, 8'h04);
    preload(16'h0014, 8'hFF);
    issue(1'b0, 16'h0010, 16'h0011, 16'd4, 8'h00);
    wait_done("ovl_done");
    tick();
    for (int i = 0; i < 4; i++) chk("ovl_mem", 32'(mem[16'h0011 + 16'(i)]), 32'(ov[i]));
    chk("ovl_src0", 32'(mem[16'h0010]), 32'h01);

    // reset while waiting on a read
    issue(1'b0, 16'h0200, 16'h0600, 16'd3, 8'h00);
    tick();
    chk("rstmid_addr", 32'(mem_addr), 32'h0200);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_rem", 32'(remaining), 32'd0);
    chk("rstmid_we", 32'(mem_we), 32'd0);
    chk("rstmid_addr0", 32'(mem_addr), 32'd0);
    chk("rstmid_wdata", 32'(mem_wdata), 32'd0);
    snap_done = done_cnt;
    for (int i = 0; i < 5; i++) tick();
    chk("rstmid_nodone", 32'(done_cnt - snap_done), 32'd0);

    // abort in idle has no effect; next command runs normally
    abort = 1'b1;
    tick();
    abort = 1'b0;
    snap_wr = wr_cnt;
    issue(1'b1, 16'h0000, 16'h0700, 16'd2, 8'h9D);
    wait_done("post_done");
    chk("post_rem", 32'(remaining), 32'd0);
    tick();
    chk("post_writes", 32'(wr_cnt - snap_wr), 32'd2);
    chk("post_mem0", 32'(mem[16'h0700]), 32'h9D);
    chk("post_mem1", 32'(mem[16'h0701]), 32'h9D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
